sample_scheduler: RTL and testbench
===================================

Name: sample_scheduler

Overview:
- Sequencing controller that feeds the jitter-hash stage. It accepts one triangle and its bounding box per handshake, and walks the box in raster order at the subsample pitch.
- Each cycle in the walk it drives one candidate sample (plus the held triangle and colour) into the R14 hash stage.
- It applies backpressure upstream through halt_RnnnnL while a walk is in progress.
- Sits between bounding-box generation (R13) and the hash stage (R14). The hash stage never stalls.

Parameters:
- SIGFIG, 24, fixed-point word width of every coordinate and colour
- RADIX, 10, fractional bits; one pixel = 1<<RADIX
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex
- COLORS, 3, colour channels

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- tri_R13S  in  signed SIGFIG x VERTS x AXIS  triangle from bbox stage
- color_R13U  in  unsigned SIGFIG x COLORS  triangle colour
- box_R13S  in  signed SIGFIG x 2 x 2  [0]=lower-left, [1]=upper-right; [.][0]=x, [.][1]=y
- validTri_R13H  in  1  triangle/box valid
- subSample_RnnnnU  in  4  one-hot subsample pitch select
- halt_RnnnnL  out  1  high = ready to accept a triangle; low = upstream must hold
- tri_R14S  out  signed SIGFIG x VERTS x AXIS  held triangle
- color_R14U  out  unsigned SIGFIG x COLORS  held colour
- sample_R14S  out  signed SIGFIG x 2  current sample, [0]=x, [1]=y
- validSamp_R14H  out  1  sample/triangle outputs valid this cycle

Behaviour:
- Reset and clock: one clock (clk). rst is synchronous, active-high.
- Reset values: state=WAIT, halt_RnnnnL=1, validSamp_R14H=0, and all data outputs and internal box/step registers are 0.
- Reset asserted mid-walk abandons the triangle; no further samples are emitted.
- States:
  - WAIT: halt_RnnnnL=1, validSamp_R14H=0, data outputs hold their last value.
  - TEST: halt_RnnnnL=0, validSamp_R14H=1.
  - halt_RnnnnL is a registered function of state, so it is low on exactly the cycles validSamp_R14H is high.
- Accept: in WAIT, when validTri_R13H=1 at a rising edge, latch the following and go to TEST:
  - tri, color and box;
  - step derived from subSample_RnnnnU;
  - sample_R14S = box lower-left.
- Accept latency: accept at edge N gives the first sample valid in cycle N+1.
- Step selection (sampled at accept only; changes mid-walk are ignored):
  - [3] gives 1<<RADIX.
  - [2] gives 1<<(RADIX-1).
  - [1] gives 1<<(RADIX-2).
  - [0] gives 1<<(RADIX-3).
  - Not one-hot: highest set bit wins. All-zero: 1<<RADIX.
- Advance, each TEST cycle, with nx = x+step and ny = y+step computed at SIGFIG+1 bits signed (no wrap):
  - nx <= ur.x: x=nx.
  - nx > ur.x and ny <= ur.y: x=ll.x, y=ny.
  - nx > ur.x and ny > ur.y: current sample is the last; next state is WAIT.
- Sample count: the walk emits every (ll.x+i*step, ll.y+j*step) with coordinate <= ur per axis, in raster order (x fastest), one per cycle, with no gaps.
- Degenerate boxes: ll==ur emits exactly one sample. An inverted box (ll>ur on either axis) also emits exactly one sample at ll.
- Back-to-back triangles: after the last sample the controller spends one WAIT cycle (one bubble) before the next triangle's first sample. validTri_R13H held high during TEST is ignored; upstream must hold its data while halt_RnnnnL=0.
- Held data: tri_R14S and color_R14U are constant for every sample of one walk.
- Box alignment: the box is expected to be aligned to the step. The controller performs no snapping or clamping.

Test Plan:
- Reset then idle: rst high for 2 cycles, validTri low -> halt=1, validSamp=0 and all outputs 0 for 10 cycles.
- Pixel walk: RADIX=10, subSample=4'b1000, box ll=(0,0), ur=(2048,1024), validTri pulse.
  - Expect 6 consecutive valid cycles: (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024).
  - halt low for exactly those 6 cycles; tri/color equal the latched inputs throughout.
- MSAA pitch: subSample=4'b0001, box (0,0)-(256,128) -> step 128, samples (0,0),(128,0),(256,0),(0,128),(128,128),(256,128). Then subSample is changed to 4'b1000 mid-walk -> walk unaffected.
- Degenerate and inverted boxes: box (512,512)-(512,512) -> exactly 1 sample (512,512). Box ll=(1024,0), ur=(0,0) -> exactly 1 sample (1024,0), then halt=1.
- Back-to-back: two triangles presented with validTri held high -> first walk completes, exactly 1 idle cycle, then the second triangle's first sample. The second triangle's data is not latched during the first walk.
- Reset mid-walk: 100-sample box, rst asserted on the 5th sample cycle -> next cycle validSamp=0, halt=1, outputs 0. A new triangle is accepted normally afterwards.

Source files
------------

// File: rtl/sample_scheduler.sv
// sample_scheduler: walks a triangle's bounding box in raster order at the subsample pitch,
// emitting one candidate sample per cycle and holding off upstream while the walk runs.
module sample_scheduler #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H
);
    typedef enum logic {WAIT, TEST} state_e;

    localparam logic [SIGFIG-1:0] PIX = {{(SIGFIG-1){1'b0}}, 1'b1} << RADIX;

    state_e                    state_q;
    logic                      halt_q;
    logic                      valid_q;
    logic signed [SIGFIG-1:0]  tri_q [VERTS][AXIS];
    logic        [SIGFIG-1:0]  color_q [COLORS];
    logic signed [SIGFIG-1:0]  box_q [2][2];
    logic signed [SIGFIG-1:0]  samp_q [2];
    logic        [SIGFIG-1:0]  step_q;
    logic        [SIGFIG-1:0]  step_d;
    logic signed [SIGFIG:0]    nx_d;
    logic signed [SIGFIG:0]    ny_d;
    logic                      x_fits;
    logic                      y_fits;

    // highest set bit wins; no bits set falls back to one-pixel pitch
    always_comb begin
        step_d = subSample_RnnnnU[3] ? PIX :
                 subSample_RnnnnU[2] ? PIX >> 1 :
                 subSample_RnnnnU[1] ? PIX >> 2 :
                 subSample_RnnnnU[0] ? PIX >> 3 : PIX;
        nx_d   = $signed({samp_q[0][SIGFIG-1], samp_q[0]}) + $signed({1'b0, step_q});
        ny_d   = $signed({samp_q[1][SIGFIG-1], samp_q[1]}) + $signed({1'b0, step_q});
        x_fits = nx_d <= $signed({box_q[1][0][SIGFIG-1], box_q[1][0]});
        y_fits = ny_d <= $signed({box_q[1][1][SIGFIG-1], box_q[1][1]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
            halt_q  <= 1'b1;
            valid_q <= 1'b0;
            tri_q   <= '{default: '0};
            color_q <= '{default: '0};
            box_q   <= '{default: '0};
            samp_q  <= '{default: '0};
            step_q  <= '0;
        end else if (state_q == WAIT) begin
            if (validTri_R13H) begin
                state_q <= TEST;
                halt_q  <= 1'b0;
                valid_q <= 1'b1;
                tri_q   <= tri_R13S;
                color_q <= color_R13U;
                box_q   <= box_R13S;
                samp_q  <= box_R13S[0];
                step_q  <= step_d;
            end
        end else if (x_fits) begin
            samp_q[0] <= nx_d[SIGFIG-1:0];
        end else if (y_fits) begin
            samp_q[0] <= box_q[0][0];
            samp_q[1] <= ny_d[SIGFIG-1:0];
        end else begin
            state_q <= WAIT;
            halt_q  <= 1'b1;
            valid_q <= 1'b0;
        end
    end

    assign halt_RnnnnL    = halt_q;
    assign validSamp_R14H = valid_q;
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = samp_q;
endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: directed scenarios for the box-walking sample scheduler.
module tb_sample_scheduler;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [23:0] tri_i [3][3];
    logic        [23:0] color_i [3];
    logic signed [23:0] box_i [2][2];
    logic               valid_tri = 1'b0;
    logic        [3:0]  sub = 4'b1000;
    logic               halt;
    logic signed [23:0] tri_o [3][3];
    logic        [23:0] color_o [3];
    logic signed [23:0] samp_o [2];
    logic               valid_samp;
    int                 vectors = 0;
    int                 errors = 0;

    sample_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_i),
        .color_R13U       (color_i),
        .box_R13S         (box_i),
        .validTri_R13H    (valid_tri),
        .subSample_RnnnnU (sub),
        .halt_RnnnnL      (halt),
        .tri_R14S         (tri_o),
        .color_R14U       (color_o),
        .sample_R14S      (samp_o),
        .validSamp_R14H   (valid_samp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int base, input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] s);
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                tri_i[v][a] = 24'(base + v * 3 + a);
        for (int c = 0; c < 3; c++)
            color_i[c] = 24'(base + 50 + c);
        box_i[0][0] = 24'(llx);
        box_i[0][1] = 24'(lly);
        box_i[1][0] = 24'(urx);
        box_i[1][1] = 24'(ury);
        sub = s;
    endtask

    task automatic test_reset();
        logic bad;
        load(0, 0, 0, 0, 0, 4'b1000);
        rst = 1'b1;
        valid_tri = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if ({halt, valid_samp} !== 2'b10) begin
                errors++;
                $display("FAIL reset_ctl cycle %0d: halt/valid=%b expected 10", i, {halt, valid_samp});
            end
            bad = (samp_o[0] !== 24'd0) || (samp_o[1] !== 24'd0);
            for (int v = 0; v < 3; v++) begin
                bad = bad || (color_o[v] !== 24'd0);
                for (int a = 0; a < 3; a++)
                    bad = bad || (tri_o[v][a] !== 24'd0);
            end
            vectors++;
            if (bad) begin
                errors++;
                $display("FAIL reset_data cycle %0d: sample=(%0d,%0d) tri00=%0d color0=%0d expected all 0",
                         i, samp_o[0], samp_o[1], tri_o[0][0], color_o[0]);
            end
            tick();
        end
    endtask

    task automatic test_pixel_walk();
        int ex[6] = '{0, 1024, 2048, 0, 1024, 2048};
        int ey[6] = '{0, 0, 0, 1024, 1024, 1024};
        logic bad;
        load(16, 0, 0, 2048, 1024, 4'b1000);
        valid_tri = 1'b1;
        tick();
        valid_tri = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if ({halt, valid_samp} !== 2'b01) begin
                errors++;
                $display("FAIL pixel_ctl #%0d: halt/valid=%b expected 01", i, {halt, valid_samp});
            end
            vectors++;
            if (samp_o[0] !== 24'(ex[i]) || samp_o[1] !== 24'(ey[i])) begin
                errors++;
                $display("FAIL pixel_sample #%0d: got (%0d,%0d) expected (%0d,%0d)",
                         i, samp_o[0], samp_o[1], ex[i], ey[i]);
            end
            bad = 1'b0;
            for (int v = 0; v < 3; v++) begin
                bad = bad || (color_o[v] !== 24'(16 + 50 + v));
                for (int a = 0; a < 3; a++)
                    bad = bad || (tri_o[v][a] !== 24'(16 + v * 3 + a));
            end
            vectors++;
            if (bad) begin
                errors++;
                $display("FAIL pixel_held #%0d: tri00=%0d color0=%0d expected 16/66", i, tri_o[0][0], color_o[0]);
            end
            tick();
        end
        vectors++;
        if ({halt, valid_samp} !== 2'b10) begin
            errors++;
            $display("FAIL pixel_end: halt/valid=%b expected 10", {halt, valid_samp});
        end
    endtask

    task automatic test_msaa_pitch();
        int ex[6] = '{0, 128, 256, 0, 128, 256};
        int ey[6] = '{0, 0, 0, 128, 128, 128};
        load(200, 0, 0, 256, 128, 4'b0001);
        valid_tri = 1'b1;
        tick();
        valid_tri = 1'b0;
        sub = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (valid_samp !== 1'b1 || samp_o[0] !== 24'(ex[i]) || samp_o[1] !== 24'(ey[i])) begin
                errors++;
                $display("FAIL msaa_sample #%0d: valid=%b got (%0d,%0d) expected valid=1 (%0d,%0d)",
                         i, valid_samp, samp_o[0], samp_o[1], ex[i], ey[i]);
            end
            tick();
        end
        vectors++;
        if ({halt, valid_samp} !== 2'b10) begin
            errors++;
            $display("FAIL msaa_end: halt/valid=%b expected 10", {halt, valid_samp});
        end
    endtask

    task automatic test_degenerate();
        load(300, 512, 512, 512, 512, 4'b0100);
        valid_tri = 1'b1;
        tick();
        valid_tri = 1'b0;
        vectors++;
        if ({halt, valid_samp} !== 2'b01 || samp_o[0] !== 24'sd512 || samp_o[1] !== 24'sd512) begin
            errors++;
            $display("FAIL point_box: halt/valid=%b got (%0d,%0d) expected 01 (512,512)",
                     {halt, valid_samp}, samp_o[0], samp_o[1]);
        end
        tick();
        vectors++;
        if ({halt, valid_samp} !== 2'b10) begin
            errors++;
            $display("FAIL point_box_end: halt/valid=%b expected 10", {halt, valid_samp});
        end
        load(400, 1024, 0, 0, 0, 4'b1000);
        valid_tri = 1'b1;
        tick();
        valid_tri = 1'b0;
        vectors++;
        if ({halt, valid_samp} !== 2'b01 || samp_o[0] !== 24'sd1024 || samp_o[1] !== 24'sd0) begin
            errors++;
            $display("FAIL inverted_box: halt/valid=%b got (%0d,%0d) expected 01 (1024,0)",
                     {halt, valid_samp}, samp_o[0], samp_o[1]);
        end
        tick();
        vectors++;
        if ({halt, valid_samp} !== 2'b10 || samp_o[0] !== 24'sd1024) begin
            errors++;
            $display("FAIL inverted_box_end: halt/valid=%b x=%0d expected 10 and held x=1024",
                     {halt, valid_samp}, samp_o[0]);
        end
    endtask

    task automatic test_back_to_back();
        load(500, 0, 0, 1024, 0, 4'b1000);
        valid_tri = 1'b1;
        tick();
        load(600, 4096, 2048, 4096, 2048, 4'b1000);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (valid_samp !== 1'b1 || samp_o[0] !== 24'(i * 1024) || samp_o[1] !== 24'sd0 ||
                tri_o[2][2] !== 24'(508) || color_o[1] !== 24'(551)) begin
                errors++;
                $display("FAIL b2b_first #%0d: valid=%b got (%0d,%0d) tri22=%0d color1=%0d expected 1 (%0d,0) 508 551",
                         i, valid_samp, samp_o[0], samp_o[1], tri_o[2][2], color_o[1], i * 1024);
            end
            tick();
        end
        vectors++;
        if ({halt, valid_samp} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_bubble: halt/valid=%b expected 10", {halt, valid_samp});
        end
        tick();
        valid_tri = 1'b0;
        vectors++;
        if (valid_samp !== 1'b1 || samp_o[0] !== 24'sd4096 || samp_o[1] !== 24'sd2048 ||
            tri_o[2][2] !== 24'(608) || color_o[1] !== 24'(651)) begin
            errors++;
            $display("FAIL b2b_second: valid=%b got (%0d,%0d) tri22=%0d color1=%0d expected 1 (4096,2048) 608 651",
                     valid_samp, samp_o[0], samp_o[1], tri_o[2][2], color_o[1]);
        end
        tick();
        vectors++;
        if ({halt, valid_samp} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_end: halt/valid=%b expected 10", {halt, valid_samp});
        end
    endtask

    task automatic test_reset_mid_walk();
        load(700, 0, 0, 9216, 9216, 4'b1000);
        valid_tri = 1'b1;
        tick();
        valid_tri = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (valid_samp !== 1'b1 || samp_o[0] !== 24'(k * 1024) || samp_o[1] !== 24'sd0) begin
                errors++;
                $display("FAIL midrst_walk #%0d: valid=%b got (%0d,%0d) expected 1 (%0d,0)",
                         k, valid_samp, samp_o[0], samp_o[1], k * 1024);
            end
            if (k < 4) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({halt, valid_samp} !== 2'b10 || samp_o[0] !== 24'sd0 || samp_o[1] !== 24'sd0 ||
            tri_o[1][1] !== 24'sd0 || color_o[2] !== 24'd0) begin
            errors++;
            $display("FAIL midrst_clear: halt/valid=%b sample=(%0d,%0d) tri11=%0d color2=%0d expected 10 and zeros",
                     {halt, valid_samp}, samp_o[0], samp_o[1], tri_o[1][1], color_o[2]);
        end
        load(800, 1024, 1024, 2048, 1024, 4'b1000);
        valid_tri = 1'b1;
        tick();
        valid_tri = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (valid_samp !== 1'b1 || samp_o[0] !== 24'(1024 + i * 1024) || samp_o[1] !== 24'sd1024 ||
                tri_o[1][1] !== 24'(804)) begin
                errors++;
                $display("FAIL midrst_new #%0d: valid=%b got (%0d,%0d) tri11=%0d expected 1 (%0d,1024) 804",
                         i, valid_samp, samp_o[0], samp_o[1], tri_o[1][1], 1024 + i * 1024);
            end
            tick();
        end
        vectors++;
        if ({halt, valid_samp} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_end: halt/valid=%b expected 10", {halt, valid_samp});
        end
    endtask

    initial begin
        test_reset();
        test_pixel_walk();
        test_msaa_pitch();
        test_degenerate();
        test_back_to_back();
        test_reset_mid_walk();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
